// File: rtl/pbuf_pkg.sv
// pbuf_pkg: shared defaults, widths and helpers for the multi-bank input buffer.
package pbuf_pkg;
    localparam int DEF_DATA_W    = 16;
    localparam int DEF_DEPTH     = 8;
    localparam int DEF_NUM_BANKS = 2;
    localparam int BANK_W        = $clog2(DEF_NUM_BANKS);
    localparam int PTR_W         = $clog2(DEF_DEPTH);

    typedef logic [DEF_DATA_W-1:0] word_t;

    function automatic int wrap_inc(input int v, input int n);
        return (v == n - 1) ? 0 : v + 1;
    endfunction
endpackage

// File: rtl/buffer_bank.sv
// buffer_bank: one DEPTH x DATA_W storage array with a registered read port.
module buffer_bank
    import pbuf_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int PW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [PW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [PW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    always_ff @(posedge clk) begin
        if (rst) rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/multi_bank_buffer.sv
// multi_bank_buffer: N-bank round-robin capture buffer with back-pressure and overflow flag.
// Optional partial-bank flush via the PBUF_FLUSH_EN macro.
module multi_bank_buffer
    import pbuf_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int NUM_BANKS = DEF_NUM_BANKS,
    localparam int BW       = $clog2(NUM_BANKS),
    localparam int PW       = $clog2(DEPTH)
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 CLR,
`ifdef PBUF_FLUSH_EN
    input  logic                 flush,
`endif
    input  logic                 EN,
    input  logic [DATA_W-1:0]    dataIn,
    output logic                 wr_ready,
    input  logic                 RD,
    output logic                 rd_avail,
    output logic [DATA_W-1:0]    dataOut,
    output logic                 rd_valid,
    output logic                 rd_last,
    output logic [BW-1:0]        wr_bank,
    output logic [BW-1:0]        rd_bank,
    output logic [NUM_BANKS-1:0] FULL,
    output logic                 overflow
);
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [BW-1:0]        wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d, rd_sel_q;
    logic [NUM_BANKS-1:0] full_q, full_d;
    logic                 ovf_q, ovf_d, rd_valid_q, rd_last_q;
    logic                 live, wr_acc, rd_acc, wr_close, rd_end;
    logic [DATA_W-1:0]    bank_rdata [NUM_BANKS];

    assign live     = !(Rst || CLR);
    assign wr_ready = !full_q[wr_bank_q];
    assign rd_avail = full_q[rd_bank_q];
    assign wr_acc   = live && EN && wr_ready;
    assign rd_acc   = live && RD && rd_avail;

`ifdef PBUF_FLUSH_EN
    // Per-bank word count; banks closed by a flush drain early.
    logic [PW:0] len_q [NUM_BANKS];
    logic [PW:0] wr_cnt;
    assign wr_cnt   = {1'b0, wr_ptr_q} + (PW+1)'(wr_acc);
    assign wr_close = (wr_acc && wr_ptr_q == PW'(DEPTH - 1)) || (live && flush && wr_ptr_q != '0);
    assign rd_end   = rd_acc && ({1'b0, rd_ptr_q} == len_q[rd_bank_q] - 1'b1);
    always_ff @(posedge Clk) begin
        if (wr_close) len_q[wr_bank_q] <= wr_cnt;
    end
`else
    assign wr_close = wr_acc && wr_ptr_q == PW'(DEPTH - 1);
    assign rd_end   = rd_acc && rd_ptr_q == PW'(DEPTH - 1);
`endif

    // Writer only touches !FULL banks and reader only FULL ones, so both updates can apply.
    always_comb begin
        full_d    = full_q;
        wr_ptr_d  = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
        wr_bank_d = wr_bank_q;
        rd_ptr_d  = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
        rd_bank_d = rd_bank_q;
        ovf_d     = ovf_q || (EN && !wr_ready);
        if (wr_close) begin
            full_d[wr_bank_q] = 1'b1;
            wr_ptr_d          = '0;
            wr_bank_d         = BW'(wrap_inc(int'(wr_bank_q), NUM_BANKS));
        end
        if (rd_end) begin
            full_d[rd_bank_q] = 1'b0;
            rd_ptr_d          = '0;
            rd_bank_d         = BW'(wrap_inc(int'(rd_bank_q), NUM_BANKS));
        end
    end

    always_ff @(posedge Clk) begin
        if (!live) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            wr_bank_q  <= '0;
            rd_bank_q  <= '0;
            full_q     <= '0;
            ovf_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            full_q     <= full_d;
            ovf_q      <= ovf_d;
            rd_valid_q <= rd_acc;
            rd_last_q  <= rd_end;
        end
    end

    // Remembers which bank produced dataOut; CLR leaves it so dataOut holds.
    always_ff @(posedge Clk) begin
        if (Rst) rd_sel_q <= '0;
        else if (rd_acc) rd_sel_q <= rd_bank_q;
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        buffer_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PW(PW)) u_bank (
            .clk     (Clk),
            .rst     (Rst),
            .we_i    (wr_acc && wr_bank_q == BW'(b)),
            .waddr_i (wr_ptr_q),
            .wdata_i (dataIn),
            .re_i    (rd_acc && rd_bank_q == BW'(b)),
            .raddr_i (rd_ptr_q),
            .rdata_o (bank_rdata[b])
        );
    end

    assign dataOut  = bank_rdata[rd_sel_q];
    assign rd_valid = rd_valid_q;
    assign rd_last  = rd_last_q;
    assign wr_bank  = wr_bank_q;
    assign rd_bank  = rd_bank_q;
    assign FULL     = full_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_multi_bank_buffer.sv
// tb_multi_bank_buffer: scoreboard bench for a 2x8 and a 3x4 multi_bank_buffer.
module tb_multi_bank_buffer;
    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        Rst = 1'b1;
    logic        clr0 = 0, en0 = 0, rd0 = 0, clr1 = 0, en1 = 0, rd1 = 0;
    logic [15:0] din0 = 0, din1 = 0;
    logic        wr_ready0, rd_avail0, rd_valid0, rd_last0, overflow0, wr_bank0, rd_bank0;
    logic        wr_ready1, rd_avail1, rd_valid1, rd_last1, overflow1;
    logic [1:0]  wr_bank1, rd_bank1, full0;
    logic [2:0]  full1;
    logic [15:0] dout0, dout1;

    multi_bank_buffer u_dut0 (
        .Clk(Clk), .Rst(Rst), .CLR(clr0),
`ifdef PBUF_FLUSH_EN
        .flush(1'b0),
`endif
        .EN(en0), .dataIn(din0), .wr_ready(wr_ready0), .RD(rd0), .rd_avail(rd_avail0),
        .dataOut(dout0), .rd_valid(rd_valid0), .rd_last(rd_last0), .wr_bank(wr_bank0),
        .rd_bank(rd_bank0), .FULL(full0), .overflow(overflow0)
    );

    multi_bank_buffer #(.NUM_BANKS(3), .DEPTH(4)) u_dut1 (
        .Clk(Clk), .Rst(Rst), .CLR(clr1),
`ifdef PBUF_FLUSH_EN
        .flush(1'b0),
`endif
        .EN(en1), .dataIn(din1), .wr_ready(wr_ready1), .RD(rd1), .rd_avail(rd_avail1),
        .dataOut(dout1), .rd_valid(rd_valid1), .rd_last(rd_last1), .wr_bank(wr_bank1),
        .rd_bank(rd_bank1), .FULL(full1), .overflow(overflow1)
    );

    // Reference model: words written/read since the last clear define everything else.
    typedef struct packed {logic [15:0] d; logic last;} exp_t;
    int          wcnt[2], rcnt[2];
    int          dep[2] = '{8, 4};
    int          nbk[2] = '{2, 3};
    bit          ovf[2];
    logic [15:0] last_out[2];
    logic [15:0] dq0[$], dq1[$];
    exp_t        sb0[$], sb1[$];
    int          n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input int id, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0d expected %0d at %0t", nm, id, act, exp, $time);
        end
    endtask

    task automatic check_state(input int id);
        int nf   = wcnt[id] / dep[id] - rcnt[id] / dep[id];
        int rb   = (rcnt[id] / dep[id]) % nbk[id];
        int mask = 0;
        for (int i = 0; i < nf; i++) mask |= 1 << ((rb + i) % nbk[id]);
        chk("wr_ready", id, id ? int'(wr_ready1) : int'(wr_ready0), int'(nf < nbk[id]));
        chk("rd_avail", id, id ? int'(rd_avail1) : int'(rd_avail0), int'(nf > 0));
        chk("wr_bank", id, id ? int'(wr_bank1) : int'(wr_bank0), (wcnt[id] / dep[id]) % nbk[id]);
        chk("rd_bank", id, id ? int'(rd_bank1) : int'(rd_bank0), rb);
        chk("FULL", id, id ? int'(full1) : int'(full0), mask);
        chk("overflow", id, id ? int'(overflow1) : int'(overflow0), int'(ovf[id]));
        chk("dataOut", id, id ? int'(dout1) : int'(dout0), int'(last_out[id]));
    endtask

    task automatic step(input int id, input bit en, input bit rd, input bit clr, input logic [15:0] d);
        int  nf;
        bit  wrdy, ravl;
        exp_t e;
        @(negedge Clk);
        check_state(id);
        nf   = wcnt[id] / dep[id] - rcnt[id] / dep[id];
        wrdy = nf < nbk[id];
        ravl = nf > 0;
        en0 = !id && en; rd0 = !id && rd; clr0 = !id && clr; din0 = d;
        en1 = id && en;  rd1 = id && rd;  clr1 = id && clr;  din1 = d;
        if (clr) begin
            wcnt[id] = 0; rcnt[id] = 0; ovf[id] = 0;
            if (id) dq1.delete(); else dq0.delete();
        end else begin
            if (rd && ravl) begin
                e.d = id ? dq1.pop_front() : dq0.pop_front();
                e.last = ((rcnt[id] + 1) % dep[id]) == 0;
                if (id) sb1.push_back(e); else sb0.push_back(e);
                last_out[id] = e.d;
                rcnt[id]++;
            end
            if (en && wrdy) begin
                if (id) dq1.push_back(d); else dq0.push_back(d);
                wcnt[id]++;
            end else if (en) ovf[id] = 1;
        end
    endtask

    task automatic drain(input int id);
        for (int g = 0; g < 200 && (wcnt[id] / dep[id] - rcnt[id] / dep[id]) > 0; g++) step(id, 0, 1, 0, 0);
        step(id, 0, 0, 0, 0);
        step(id, 0, 0, 0, 0);
    endtask

    always @(negedge Clk) begin : mon0
        exp_t e;
        if (rd_valid0 === 1'b1) begin
            if (sb0.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL rd_valid dut0: got 1 expected 0 at %0t", $time);
            end else begin
                e = sb0.pop_front();
                chk("read_data", 0, int'(dout0), int'(e.d));
                chk("rd_last", 0, int'(rd_last0), int'(e.last));
            end
        end
    end

    always @(negedge Clk) begin : mon1
        exp_t e;
        if (rd_valid1 === 1'b1) begin
            if (sb1.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL rd_valid dut1: got 1 expected 0 at %0t", $time);
            end else begin
                e = sb1.pop_front();
                chk("read_data", 1, int'(dout1), int'(e.d));
                chk("rd_last", 1, int'(rd_last1), int'(e.last));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge Clk);
        Rst = 1'b0;
        for (int id = 0; id < 2; id++) begin
            wcnt[id] = 0; rcnt[id] = 0; ovf[id] = 0; last_out[id] = 0;
        end
        chk("rd_valid_rst", 0, int'(rd_valid0), 0);
        chk("rd_last_rst", 0, int'(rd_last0), 0);
        // Single bank fill and drain
        for (int i = 1; i <= 8; i++) step(0, 1, 0, 0, 16'(i));
        drain(0);
        // All banks full, overflow on a 17th write, then recovery
        for (int i = 0; i < 17; i++) step(0, 1, 0, 0, 16'($urandom));
        for (int i = 0; i < 10; i++) step(0, 0, 1, 0, 0);
        drain(0);
        // Concurrent streaming from a clean state
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 72; i++) step(0, i < 64, 1, 0, 16'($urandom));
        drain(0);
        chk("stream_overflow", 0, int'(overflow0), 0);
        // CLR discards a partial bank but keeps dataOut
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 16'($urandom));
        step(0, 1, 0, 1, 16'hdead);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 16'h0100 + 16'(i));
        drain(0);
        // Random traffic
        for (int i = 0; i < 300; i++) step(0, ($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 97) == 0, 16'($urandom));
        drain(0);
        // Three-bank instance: fill all, drain all, both bank indices wrap
        for (int i = 0; i < 12; i++) step(1, 1, 0, 0, 16'($urandom));
        step(1, 1, 0, 0, 16'hbeef);
        drain(1);
        for (int i = 0; i < 300; i++) step(1, ($urandom % 3) != 0, ($urandom % 4) != 0, ($urandom % 89) == 0, 16'($urandom));
        drain(1);
        chk("scoreboard_empty", 0, sb0.size(), 0);
        chk("scoreboard_empty", 1, sb1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/multi_bank_buffer.md
Name: multi_bank_buffer

Overview:
- N-bank generalisation of the ping-pong input buffer.
- A single writer fills banks in round-robin order. A single reader drains completed (full) banks in the same order.
- Sits between the sample input stage and the compute core, so capture and processing overlap.
- Adds over the two-bank version: parametrised width/depth/bank count, independent per-bank FULL flags, automatic bank switching, back-pressure and an overflow flag.

Parameters:
- DATA_W, 16, data word width in bits.
- DEPTH, 8, words per bank; must be a power of 2 and ≥2.
- NUM_BANKS, 2, number of banks; ≥2.

Ports:
- Clk  in  1  rising-edge clock.
- Rst  in  1  synchronous active-high reset.
- CLR  in  1  synchronous clear of pointers/flags; memory contents are kept.
- EN  in  1  write strobe; a write occurs when EN & wr_ready.
- dataIn  in  DATA_W  write data.
- wr_ready  out  1  high when the current write bank is not full.
- RD  in  1  read strobe; a read occurs when RD & rd_avail.
- rd_avail  out  1  high when the current read bank is full.
- dataOut  out  DATA_W  registered read data.
- rd_valid  out  1  dataOut valid; pulses the cycle after an accepted read.
- rd_last  out  1  qualifies rd_valid; marks the final word of a bank.
- wr_bank  out  clog2(NUM_BANKS)  bank currently being written.
- rd_bank  out  clog2(NUM_BANKS)  bank currently being read.
- FULL  out  NUM_BANKS  per-bank full flags.
- overflow  out  1  sticky; set when EN is asserted while wr_ready=0.

Behaviour:
- Reset (Rst=1): all pointers 0, wr_bank=rd_bank=0, FULL=0, wr_ready=1, rd_avail=0, dataOut=0, rd_valid=0, rd_last=0, overflow=0. Rst takes priority over every other input.
- CLR=1 (and Rst=0): same as reset except dataOut holds its value. Any in-flight bank data is discarded.
- Write:
  - On an accepted write, mem[wr_bank][wr_ptr] <= dataIn and wr_ptr increments.
  - When wr_ptr=DEPTH-1 is written: FULL[wr_bank] <= 1, wr_ptr <= 0, wr_bank <= (wr_bank+1) mod NUM_BANKS.
- Write back-pressure:
  - wr_ready = !FULL[wr_bank] (combinational).
  - A write attempted while wr_ready=0 is dropped and sets overflow, which holds until Rst or CLR.
- Read:
  - rd_avail = FULL[rd_bank].
  - On an accepted read, dataOut <= mem[rd_bank][rd_ptr] and rd_valid <= 1 on the next cycle (latency 1).
  - rd_ptr increments on each accepted read.
- End of bank read:
  - At rd_ptr=DEPTH-1: FULL[rd_bank] <= 0, rd_ptr <= 0, rd_bank advances modulo NUM_BANKS.
  - rd_last=1 in the same cycle as that final rd_valid.
- Bank state per bank (held in the FULL bit): FILLING/EMPTY (FULL=0) → FULL when the writer completes the bank → EMPTY when the reader completes it.
- Simultaneous events:
  - The writer and reader never address the same bank in the same cycle: the writer only touches !FULL banks, the reader only FULL banks.
  - A write completing bank k and a read completing bank j≠k in the same cycle both take effect.
  - If the reader frees bank k in the same cycle the writer stalls on bank k, wr_ready rises on the next cycle; there is no same-cycle bypass.
- All-banks-full: wr_ready=0 until the reader completes the oldest bank.
- Wrap: bank indices wrap NUM_BANKS-1 → 0. Pointers wrap DEPTH-1 → 0.

Optional Feature:
- Macro: PBUF_FLUSH_EN.
- With the macro defined:
  - Adds input `flush`. A flush on a partially written bank (wr_ptr>0) marks it FULL, records its length wr_ptr in len[wr_bank], and advances wr_bank.
  - The reader completes that bank after len words; rd_last is set accordingly.
  - flush with wr_ptr=0 is ignored. flush coinciding with an accepted write includes that word in the bank.
- Without the macro: no `flush` port and no length storage; every bank is exactly DEPTH words.

Decomposition:
- Shared package pbuf_pkg:
  - constants BANK_W=clog2(NUM_BANKS) and PTR_W=clog2(DEPTH);
  - a word typedef of DATA_W bits.
- Sub-module buffer_bank: one DEPTH×DATA_W storage array with a registered read port. It is instantiated NUM_BANKS times via generate.
- Pointer, bank-select and flag logic stays in the top level.

Test Plan:
- Rst, then write 8 words 0x0001..0x0008 (defaults) → FULL=2'b01, wr_bank=1, rd_avail=1. Read 8 → dataOut 0x0001..0x0008, one cycle after each RD; rd_last on the 8th; FULL=2'b00.
- Write 16 words with no reads → FULL=2'b11, wr_ready=0. A 17th EN → dropped, overflow=1. Read 8 → wr_ready=1 the cycle after FULL[0] clears.
- Concurrent streaming: EN every cycle; RD asserted whenever rd_avail for 64 words → no overflow, output sequence equals input sequence.
- NUM_BANKS=3, DEPTH=4: 12 writes then 12 reads → banks are drained in order 0,1,2; wr_bank and rd_bank wrap to 0.
- Write 5 words, pulse CLR, write 8 more → FULL=2'b01. Reads return only the post-CLR data; overflow=0.
- (PBUF_FLUSH_EN) Write 3 words, then flush → FULL[0]=1. Reading returns 3 words with rd_last on the 3rd. The next write lands in bank 1.
